// File: rtl/ps2_key_event_fifo.sv
// ---------------------------------------------------------------------------
// ps2_key_event_fifo
//
// Purpose:
//   This block decodes a raw PS/2 scan-code byte stream into key make and
//   break events. It handles the E0 extended prefix and the F0 break prefix.
//   It tracks which keys are held in a 512-bit bitmap, and can filter out
//   typematic repeats. Decoded events are buffered in a show-ahead FIFO, so
//   a busy consumer does not lose keypresses.
//
// Parameters:
//   DEPTH          FIFO depth in events (power of two, >= 2)
//   FILTER_REPEAT  1 = drop makes for keys already held, 0 = pass every make
//   TIMEOUT_CYCLES idle cycles after a prefix before it is abandoned (0 = off)
//
// Ports:
//   clock          system clock, posedge
//   resetn         synchronous active-low reset
//   ps2_byte       received PS/2 byte
//   ps2_byte_valid one-cycle strobe qualifying ps2_byte
//   ev_pop         consumer removes the head event (ignored when empty)
//   ovf_clear      clears the sticky overflow flag
//   ev_valid       FIFO non-empty
//   ev_data        head event {released, extended, code}, 0 when empty
//   ev_count       number of stored events
//   overflow       sticky: an event was dropped because the FIFO was full
//   any_key_down   at least one key held (registered from the bitmap)
// ---------------------------------------------------------------------------
module ps2_key_event_fifo #(
  parameter int DEPTH          = 8,
  parameter int FILTER_REPEAT  = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [7:0]               ps2_byte,
  input  logic                     ps2_byte_valid,
  input  logic                     ev_pop,
  input  logic                     ovf_clear,
  output logic                     ev_valid,
  output logic [9:0]               ev_data,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  output logic                     any_key_down
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam bit FILT   = (FILTER_REPEAT != 0);
  localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [511:0]    held_q;
  logic            any_q;
  logic            ovf_q;
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      mem_q [DEPTH];

  logic            emit;
  logic            ev_rel;
  logic            ev_ext;
  logic [8:0]      key_idx;
  logic            accept;
  logic            full;
  logic            pop_ok;
  logic            push_ok;
  logic            ovf_set;

  // Decoder: next state and event extraction for the current byte
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    ev_rel  = 1'b0;
    ev_ext  = 1'b0;
    if (ps2_byte_valid) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (ps2_byte)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            // E1 (pause prefix) and controller responses are not key events
            8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
            default: emit = 1'b1;
          endcase
        end
        S_EXT: begin
          if (ps2_byte == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (ps2_byte == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            emit    = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          // A second prefix after F0 is a protocol error: abandon silently
          state_d = S_IDLE;
          if (ps2_byte != 8'hE0 && ps2_byte != 8'hF0) begin
            emit   = 1'b1;
            ev_rel = 1'b1;
          end
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (ps2_byte != 8'hE0 && ps2_byte != 8'hF0) begin
            emit   = 1'b1;
            ev_rel = 1'b1;
            ev_ext = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (TMO_EN && state_q != S_IDLE && tmo_q == TMO_LAST) begin
      state_d = S_IDLE;
    end
  end

  // The timeout counter only runs while a prefix is pending and no byte arrives
  always_comb begin
    tmo_d = '0;
    if (TMO_EN && !ps2_byte_valid && state_q != S_IDLE && state_d != S_IDLE) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Repeat filter, FIFO handshake and overflow detection
  always_comb begin
    key_idx = {ev_ext, ps2_byte};
    accept  = emit && !(FILT && !ev_rel && held_q[key_idx]);
    full    = (cnt_q == FULL_CNT);
    pop_ok  = ev_pop && (cnt_q != '0);
    // A simultaneous pop frees the slot, so a full FIFO still takes the push
    push_ok = accept && (!full || pop_ok);
    ovf_set = accept && full && !pop_ok;
    cnt_d   = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      held_q  <= '0;
      any_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      // The bitmap follows accepted events even if the FIFO drops them
      if (accept) begin
        held_q[key_idx] <= !ev_rel;
      end
      any_q <= |held_q;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clear) begin
        ovf_q <= 1'b0;
      end
      if (push_ok) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  // Event storage: no reset needed, the outputs are gated by the count
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_q] <= {ev_rel, ev_ext, ps2_byte};
    end
  end

  assign ev_valid     = (cnt_q != '0);
  assign ev_data      = ev_valid ? mem_q[rd_q] : 10'd0;
  assign ev_count     = cnt_q;
  assign overflow     = ovf_q;
  assign any_key_down = any_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
module tb_ps2_key_event_fifo;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_byte_valid = 1'b0;
  logic       ev_pop = 1'b0;
  logic       ovf_clear = 1'b0;

  logic       ev_valid, ev_valid_b;
  logic [9:0] ev_data, ev_data_b;
  logic [3:0] ev_count, ev_count_b;
  logic       overflow, overflow_b;
  logic       any_key_down, any_key_down_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ps2_key_event_fifo #(.DEPTH(8), .FILTER_REPEAT(1), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .resetn(resetn), .ps2_byte(ps2_byte),
    .ps2_byte_valid(ps2_byte_valid), .ev_pop(ev_pop), .ovf_clear(ovf_clear),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_count(ev_count),
    .overflow(overflow), .any_key_down(any_key_down)
  );

  ps2_key_event_fifo #(.DEPTH(8), .FILTER_REPEAT(0), .TIMEOUT_CYCLES(100)) dut_nf (
    .clock(clock), .resetn(resetn), .ps2_byte(ps2_byte),
    .ps2_byte_valid(ps2_byte_valid), .ev_pop(ev_pop), .ovf_clear(ovf_clear),
    .ev_valid(ev_valid_b), .ev_data(ev_data_b), .ev_count(ev_count_b),
    .overflow(overflow_b), .any_key_down(any_key_down_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All steps start and end on a falling edge; one rising edge per step
  task automatic send(input logic [7:0] b);
    ps2_byte = b;
    ps2_byte_valid = 1'b1;
    @(negedge clock);
    ps2_byte_valid = 1'b0;
  endtask

  task automatic send_pop(input logic [7:0] b);
    ps2_byte = b;
    ps2_byte_valid = 1'b1;
    ev_pop = 1'b1;
    @(negedge clock);
    ps2_byte_valid = 1'b0;
    ev_pop = 1'b0;
  endtask

  task automatic pop();
    ev_pop = 1'b1;
    @(negedge clock);
    ev_pop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_data", 32'(ev_data), 32'd0);
    chk("rst_count", 32'(ev_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_any", 32'(any_key_down), 32'd0);

    // Make then break of 1C
    send(8'h1C);
    chk("mk_valid", 32'(ev_valid), 32'd1);
    chk("mk_data", 32'(ev_data), 32'h01C);
    chk("mk_count", 32'(ev_count), 32'd1);
    chk("mk_any_lag", 32'(any_key_down), 32'd0);
    idle(1);
    chk("mk_any", 32'(any_key_down), 32'd1);
    send(8'hF0);
    send(8'h1C);
    chk("brk_count", 32'(ev_count), 32'd2);
    chk("brk_head", 32'(ev_data), 32'h01C);
    pop();
    chk("brk_data", 32'(ev_data), 32'h21C);
    chk("brk_any", 32'(any_key_down), 32'd0);
    pop();
    chk("empty_valid", 32'(ev_valid), 32'd0);
    chk("empty_data", 32'(ev_data), 32'd0);
    pop();
    chk("pop_empty", 32'(ev_count), 32'd0);

    // Extended make/break with ignored responses in between
    send(8'hE0); send(8'h75);
    chk("ext_mk", 32'(ev_data), 32'h175);
    send(8'hFA); send(8'hAA);
    chk("ignored", 32'(ev_count), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_cnt", 32'(ev_count), 32'd2);
    pop();
    chk("ext_brk", 32'(ev_data), 32'h375);
    pop();

    // Repeat filter versus pass-through
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    chk("filt_cnt", 32'(ev_count), 32'd2);
    chk("nofilt_cnt", 32'(ev_count_b), 32'd4);
    chk("filt_head", 32'(ev_data), 32'h01C);
    pop();
    chk("filt_second", 32'(ev_data), 32'h21C);
    chk("nofilt_second", 32'(ev_data_b), 32'h01C);
    pop();
    chk("nofilt_left", 32'(ev_count_b), 32'd2);

    // Overflow behaviour
    do_reset();
    for (int i = 1; i <= 9; i++) send(8'(8'h10 + i));
    chk("ovf_count", 32'(ev_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(ev_data), 32'h011);
    send_pop(8'h1A);
    chk("pp_count", 32'(ev_count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd1);
    chk("pp_head", 32'(ev_data), 32'h012);
    ovf_clear = 1'b1;
    @(negedge clock);
    ovf_clear = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    ovf_clear = 1'b1;
    send(8'h1B);
    ovf_clear = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_cnt2", 32'(ev_count), 32'd8);
    pop();
    chk("ovf_pop_head", 32'(ev_data), 32'h013);
    chk("ovf_pop_cnt", 32'(ev_count), 32'd7);

    // Timeout boundary: 99 idle cycles keeps the prefix, 100 drops it
    do_reset();
    send(8'hF0);
    idle(99);
    send(8'h1C);
    chk("tmo_keep", 32'(ev_data), 32'h21C);
    pop();
    send(8'hF0);
    idle(100);
    send(8'h1C);
    chk("tmo_cnt", 32'(ev_count), 32'd1);
    chk("tmo_drop", 32'(ev_data), 32'h01C);

    // Reset in the middle of a prefix sequence
    do_reset();
    send(8'h11); send(8'h12); send(8'h13);
    chk("pre_cnt", 32'(ev_count), 32'd3);
    send(8'hE0); send(8'hF0);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    chk("mid_cnt", 32'(ev_count), 32'd0);
    chk("mid_valid", 32'(ev_valid), 32'd0);
    idle(1);
    chk("mid_any", 32'(any_key_down), 32'd0);
    send(8'h75);
    chk("mid_after", 32'(ev_data), 32'h075);
    chk("mid_after_cnt", 32'(ev_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
Successor to the single-key PS/2 cleaner. Consumes the raw PS/2 byte stream (one strobe per received byte) and decodes full make/break sequences, including the E0 extended prefix. Tracks which keys are held, optionally filters typematic repeats, and buffers decoded key events in a parametrised show-ahead FIFO. Sits between the PS/2 receiver and the game/ASCII logic, so no keypress is lost while the consumer is busy.

Parameters:
DEPTH, 8, FIFO depth in events; power of two, minimum 2
FILTER_REPEAT, 1, 1 = drop make codes for keys already held; 0 = pass every make
TIMEOUT_CYCLES, 50000, max clock cycles between a prefix byte and its follow-up before the prefix is discarded; 0 disables the timeout

Ports:
clock  input  1  system clock; all logic on posedge
resetn  input  1  synchronous, active-low reset
ps2_byte  input  8  received PS/2 byte
ps2_byte_valid  input  1  one-cycle strobe, ps2_byte valid this cycle
ev_pop  input  1  consumer removes head event this cycle; ignored when ev_valid=0
ovf_clear  input  1  clears overflow flag
ev_valid  output  1  FIFO non-empty
ev_data  output  10  head event: [9]=released, [8]=extended, [7:0]=scan code
ev_count  output  $clog2(DEPTH)+1  events stored
overflow  output  1  sticky; an event was dropped because the FIFO was full
any_key_down  output  1  at least one key is currently held

Behaviour:
- Reset (resetn=0 at posedge): FSM to IDLE, FIFO emptied, held bitmap cleared, timeout counter cleared. Outputs: ev_valid=0, ev_data=0, ev_count=0, overflow=0, any_key_down=0. Reset wins over all other inputs in the same cycle.
- The decoder FSM advances only on cycles with ps2_byte_valid=1. States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 is dropped and the FSM stays in IDLE.
  - AA, FA, FE, EE, 00, FF are ignored and the FSM stays in IDLE.
  - Any other byte is a make code -> emit {0,0,byte}.
- EXT:
  - F0 -> EXT_BRK.
  - E0 stays in EXT.
  - Any other byte -> emit {0,1,byte}, go to IDLE.
- BRK:
  - Any byte other than E0/F0 -> emit {1,0,byte}, go to IDLE.
  - E0/F0 are protocol errors -> IDLE, no event.
- EXT_BRK:
  - Any byte other than E0/F0 -> emit {1,1,byte}, go to IDLE.
  - E0/F0 are protocol errors -> IDLE, no event.
- Timeout:
  - In EXT, BRK or EXT_BRK, the counter increments every cycle without a byte and resets on each byte.
  - Reaching TIMEOUT_CYCLES -> IDLE, no event.
- Held bitmap (512 bits, indexed {extended,code}):
  - A make sets the bit; a break clears it.
  - any_key_down = OR of the bitmap, registered (1-cycle lag after the bitmap update).
- Repeat filter:
  - With FILTER_REPEAT=1, a make whose bit is already set is dropped: no push, bitmap unchanged.
  - A break for a key not held is still emitted.
- Push latency: the byte completing an event at edge N is pushed at edge N; ev_valid/ev_data reflect it after edge N if the FIFO was empty.
- FIFO:
  - Show-ahead: ev_data always shows the head entry when ev_valid=1, and is 0 when empty.
  - Pointers wrap modulo DEPTH.
  - Pop on empty is ignored.
  - Push and pop in the same cycle: count unchanged; legal when full (pop frees the slot, no overflow).
  - Push when full without pop: event dropped, FIFO unchanged, overflow=1.
- overflow stays set until ovf_clear=1. If ovf_clear and a new overflow occur in the same cycle, overflow stays 1.
- The bitmap updates even for events dropped by overflow, so held state stays accurate.

Test Plan:
- After reset, bytes 1C, F0 1C -> events 0x01C then 0x21C in order; any_key_down goes 1, then 0.
- E0 75, E0 F0 75 -> events 0x175 then 0x375; bytes FA and AA between sequences produce no events.
- FILTER_REPEAT=1, bytes 1C 1C 1C F0 1C -> exactly two events (0x01C, 0x21C); with FILTER_REPEAT=0 -> four events.
- DEPTH=8, push 9 distinct makes with no pop -> ev_count=8, overflow=1, head=first code; on a full FIFO, push and pop in the same cycle -> count stays 8, overflow unchanged; ovf_clear -> overflow=0.
- TIMEOUT_CYCLES=100, F0, wait 100 idle cycles, then 1C -> single make event 0x01C, not a break.
- resetn=0 mid-sequence (after E0 F0) with 3 events queued -> next cycle ev_count=0 and ev_valid=0; following byte 75 -> event 0x075.
